sort4_serializer: RTL and testbench



---
 rtl/sort4_serializer.sv | 118 +++++++++++
 tb/tb_sort4_serializer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sort4_serializer.sv
// Buffers up to GROUPS sorted 4-element groups and streams them out one element per handshake, smallest first.
// Optional unsigned order check on accepted groups: define SORT4_SERIALIZER_ORDER_CHECK_EN.
module sort4_serializer #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned GROUPS = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [WIDTH-1:0] c_in,
    input  logic [WIDTH-1:0] d_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       out_idx,
    output logic             out_last,
    output logic             order_err,
    output logic [7:0]       err_cnt
);

    localparam int unsigned PW = $clog2(GROUPS);
    localparam logic [PW:0] FULL = (PW+1)'(GROUPS);

    typedef logic [3:0][WIDTH-1:0] group_t;

    group_t          mem_q [GROUPS];
    group_t          mem_d [GROUPS];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW:0]     count_q, count_d;
    logic [1:0]      idx_q, idx_d;
    logic            push, pop_step, pop_group;

    // Handshake readiness comes from registered occupancy only; no pass-through when full.
    assign in_ready  = (count_q < FULL);
    assign out_valid = (count_q != '0);
    assign out_data  = mem_q[rd_ptr_q][idx_q];
    assign out_idx   = idx_q;
    assign out_last  = out_valid && (idx_q == 2'd3);

    always_comb begin
        push      = in_valid && in_ready;
        pop_step  = out_valid && out_ready;
        pop_group = pop_step && (idx_q == 2'd3);

        mem_d = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = {d_in, c_in, b_in, a_in};
        end

        wr_ptr_d = push      ? wr_ptr_q + (PW)'(1) : wr_ptr_q;
        rd_ptr_d = pop_group ? rd_ptr_q + (PW)'(1) : rd_ptr_q;
        idx_d    = pop_step  ? idx_q + 2'd1        : idx_q;

        count_d = count_q;
        case ({push, pop_group})
            2'b10:   count_d = count_q + (PW+1)'(1);
            2'b01:   count_d = count_q - (PW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < GROUPS; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            idx_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            idx_q    <= idx_d;
        end
    end

`ifdef SORT4_SERIALIZER_ORDER_CHECK_EN
    logic       sorted;
    logic       err_q, err_d;
    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        sorted = (a_in <= b_in) && (b_in <= c_in) && (c_in <= d_in);
        err_d  = err_q;
        cnt_d  = cnt_q;
        if (push && !sorted) begin
            err_d = 1'b1;
            if (cnt_q != 8'hFF) begin
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            err_q <= err_d;
            cnt_q <= cnt_d;
        end
    end

    assign order_err = err_q;
    assign err_cnt   = cnt_q;
`else
    assign order_err = 1'b0;
    assign err_cnt   = '0;
`endif

endmodule

// File: tb/tb_sort4_serializer.sv
// Directed bench for sort4_serializer: vector table for basic streaming/backpressure,
// hand-written sequences for full+pop, pointer wrap, mid-group reset and order checking.
module tb_sort4_serializer;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a_in, b_in, c_in, d_in;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [1:0] out_idx;
    logic       out_last;
    logic       order_err;
    logic [7:0] err_cnt;

    int unsigned errors = 0;
    int unsigned checks = 0;

`ifdef SORT4_SERIALIZER_ORDER_CHECK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    sort4_serializer #(.WIDTH(8), .GROUPS(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_in      (a_in),
        .b_in      (b_in),
        .c_in      (c_in),
        .d_in      (d_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .order_err (order_err),
        .err_cnt   (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       iv;
        logic [7:0] a, b, c, d;
        logic       ordy;
        logic       e_rdy;
        logic       e_vld;
        logic [7:0] e_data;
        logic [1:0] e_idx;
        logic       e_last;
    } vec_t;

    function automatic vec_t mk(input logic iv, input logic [7:0] a, input logic [7:0] b,
                                input logic [7:0] c, input logic [7:0] d, input logic ordy,
                                input logic e_rdy, input logic e_vld, input logic [7:0] e_data,
                                input logic [1:0] e_idx, input logic e_last);
        vec_t v;
        v.iv = iv; v.a = a; v.b = b; v.c = c; v.d = d; v.ordy = ordy;
        v.e_rdy = e_rdy; v.e_vld = e_vld; v.e_data = e_data; v.e_idx = e_idx; v.e_last = e_last;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic iv, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic [7:0] d, input logic ordy);
        in_valid = iv; a_in = a; b_in = b; c_in = c; d_in = d; out_ready = ordy;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    vec_t tbl[19];
    logic [7:0] ord_exp[8];

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_in_ready",  32'(in_ready),  1);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data",  32'(out_data),  0);
        chk("rst_out_idx",   32'(out_idx),   0);
        chk("rst_out_last",  32'(out_last),  0);
        chk("rst_order_err", 32'(order_err), 0);
        chk("rst_err_cnt",   32'(err_cnt),   0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic group, then backpressure with two groups held
        tbl[0]  = mk(1, 1, 2, 3, 4, 1,          1, 0, 0,  0, 0);
        tbl[1]  = mk(0, 0, 0, 0, 0, 1,          1, 1, 1,  0, 0);
        tbl[2]  = mk(0, 0, 0, 0, 0, 1,          1, 1, 2,  1, 0);
        tbl[3]  = mk(0, 0, 0, 0, 0, 1,          1, 1, 3,  2, 0);
        tbl[4]  = mk(0, 0, 0, 0, 0, 1,          1, 1, 4,  3, 1);
        tbl[5]  = mk(0, 0, 0, 0, 0, 1,          1, 0, 0,  0, 0);
        tbl[6]  = mk(1, 10, 20, 30, 40, 1,      1, 0, 0,  0, 0);
        tbl[7]  = mk(1, 50, 60, 70, 80, 0,      1, 1, 10, 0, 0);
        tbl[8]  = mk(0, 0, 0, 0, 0, 0,          0, 1, 10, 0, 0);
        tbl[9]  = mk(0, 0, 0, 0, 0, 0,          0, 1, 10, 0, 0);
        tbl[10] = mk(0, 0, 0, 0, 0, 1,          0, 1, 10, 0, 0);
        tbl[11] = mk(0, 0, 0, 0, 0, 1,          0, 1, 20, 1, 0);
        tbl[12] = mk(0, 0, 0, 0, 0, 1,          0, 1, 30, 2, 0);
        tbl[13] = mk(0, 0, 0, 0, 0, 1,          0, 1, 40, 3, 1);
        tbl[14] = mk(0, 0, 0, 0, 0, 1,          1, 1, 50, 0, 0);
        tbl[15] = mk(0, 0, 0, 0, 0, 1,          1, 1, 60, 1, 0);
        tbl[16] = mk(0, 0, 0, 0, 0, 1,          1, 1, 70, 2, 0);
        tbl[17] = mk(0, 0, 0, 0, 0, 1,          1, 1, 80, 3, 1);
        tbl[18] = mk(0, 0, 0, 0, 0, 1,          1, 0, 0,  0, 0);

        for (int i = 0; i < 19; i++) begin
            drive(tbl[i].iv, tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].d, tbl[i].ordy);
            #1;
            chk($sformatf("tbl%0d_in_ready", i),  32'(in_ready),  32'(tbl[i].e_rdy));
            chk($sformatf("tbl%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].e_vld));
            if (tbl[i].e_vld)
                chk($sformatf("tbl%0d_out_data", i), 32'(out_data), 32'(tbl[i].e_data));
            chk($sformatf("tbl%0d_out_idx", i),   32'(out_idx),   32'(tbl[i].e_idx));
            chk($sformatf("tbl%0d_out_last", i),  32'(out_last),  32'(tbl[i].e_last));
            tick();
        end

        // Full FIFO with final-element pop while a third group waits
        drive(1, 1, 2, 3, 4, 0);
        #1 chk("full_first_ready", 32'(in_ready), 1);
        tick();
        drive(1, 5, 6, 7, 8, 0);
        #1 chk("full_second_ready", 32'(in_ready), 1);
        tick();
        drive(1, 9, 10, 11, 12, 1);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("full_pop%0d_in_ready", i), 32'(in_ready), 0);
            chk($sformatf("full_pop%0d_data", i), 32'(out_data), 32'(i + 1));
            chk("full_count_max", 32'(dut.count_q <= 2), 1);
            tick();
        end
        #1;
        chk("full_accept_ready", 32'(in_ready), 1);
        chk("full_accept_data", 32'(out_data), 5);
        tick();
        drive(0, 0, 0, 0, 0, 1);
        for (int j = 1; j < 8; j++) begin
            #1;
            chk($sformatf("full_tail%0d_data", j), 32'(out_data), 32'(5 + j));
            chk($sformatf("full_tail%0d_idx", j), 32'(out_idx), 32'(j % 4));
            chk("full_count_max", 32'(dut.count_q <= 2), 1);
            tick();
        end
        #1 chk("full_drained", 32'(out_valid), 0);

        // Pointer wrap: five groups, consumer ready on alternate cycles
        begin
            int unsigned k;
            int unsigned n;
            logic        pushed;
            k = 0;
            n = 0;
            for (int cyc = 0; cyc < 200 && n < 20; cyc++) begin
                drive(k < 5, 8'(4*k), 8'(4*k + 1), 8'(4*k + 2), 8'(4*k + 3), (cyc % 2) == 0);
                #1;
                pushed = in_valid && in_ready;
                if (out_valid && out_ready) begin
                    chk($sformatf("wrap_data%0d", n), 32'(out_data), n);
                    chk($sformatf("wrap_idx%0d", n), 32'(out_idx), n % 4);
                    n++;
                end
                tick();
                if (pushed) k++;
            end
            drive(0, 0, 0, 0, 0, 0);
            chk("wrap_total_bytes", n, 20);
            #1 chk("wrap_drained", 32'(out_valid), 0);
        end

        // Reset mid-group after two bytes have been popped
        drive(1, 1, 2, 3, 4, 1);
        tick();
        drive(0, 0, 0, 0, 0, 1);
        #1 chk("mid_byte1", 32'(out_data), 1);
        tick();
        #1 chk("mid_byte2", 32'(out_data), 2);
        tick();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 0);
        chk("mid_rst_in_ready",  32'(in_ready),  1);
        chk("mid_rst_out_idx",   32'(out_idx),   0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 9, 9, 9, 9, 1);
        tick();
        drive(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("mid_after%0d_valid", i), 32'(out_valid), 1);
            chk($sformatf("mid_after%0d_data", i), 32'(out_data), 9);
            chk($sformatf("mid_after%0d_idx", i), 32'(out_idx), 32'(i));
            tick();
        end
        #1 chk("mid_after_drained", 32'(out_valid), 0);

        // Order check: unsorted group then sorted group, stream unchanged
        ord_exp = '{8'd5, 8'd3, 8'd7, 8'd8, 8'd1, 8'd1, 8'd2, 8'd2};
        drive(1, 5, 3, 7, 8, 1);
        #1 chk("ord_pre_err", 32'(order_err), 0);
        tick();
        for (int i = 0; i < 8; i++) begin
            if (i == 0) drive(1, 1, 1, 2, 2, 1);
            else        drive(0, 0, 0, 0, 0, 1);
            #1;
            chk($sformatf("ord_data%0d", i), 32'(out_data), 32'(ord_exp[i]));
            chk($sformatf("ord_idx%0d", i), 32'(out_idx), 32'(i % 4));
            if (i < 2) begin
                chk($sformatf("ord_err_flag%0d", i), 32'(order_err), 32'(CHK_EN));
                chk($sformatf("ord_err_cnt%0d", i), 32'(err_cnt), CHK_EN ? 1 : 0);
            end
            tick();
        end
        #1;
        chk("ord_drained", 32'(out_valid), 0);
        chk("ord_final_flag", 32'(order_err), 32'(CHK_EN));
        chk("ord_final_cnt", 32'(err_cnt), CHK_EN ? 1 : 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
